mem_arbiter: RTL

Shares the single data-memory port between the pipeline MEM stage (CPU) and a DMA requester, and sequences each access as a multi-cycle request/ready transaction. It sits between the MEM stage and the data memory. It stalls the pipeline until the CPU access completes. It bounds CPU priority so DMA cannot starve, and it aborts accesses that the memory never acknowledges.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_timeout.sv | 42 ++++
 rtl/mem_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, the DMA
// access width code and the wait-counter width.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CPU_ACC,
    DMA_ACC,
    CPU_DONE,
    DMA_DONE
  } arb_state_e;

  // DMA transfers are always full words.
  localparam logic [2:0] MEMOP_WORD = 3'b000;

  // Wide enough for TIMEOUT values up to 1023.
  localparam int unsigned WAIT_W = 10;

endpackage

// File: rtl/mem_arb_timeout.sv
// Wait counter for one memory access. It counts access cycles that end
// without mem_ready, and flags the TIMEOUT-th such cycle as expired.
module mem_arb_timeout
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  // Clear outside an access, count each cycle spent waiting on memory.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter holds TIMEOUT-1 completed waits, so this cycle is wait number TIMEOUT.
  assign expired = en && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single data-memory port between the CPU MEM stage and a
// DMA requester. Each access is a registered request/ready transaction:
// grant in IDLE, hold the request in an ACC state until mem_ready (or
// timeout), then spend one DONE cycle reporting the result.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned CPU_BURST_MAX = 4,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        reset,
  // CPU MEM stage
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_memop,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  output logic        cpu_err,
  // DMA requester
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wd,
  output logic [31:0] dma_rd,
  output logic        dma_done,
  output logic        dma_err,
  // Data memory
  output logic        mem_req,
  output logic        mem_we,
  output logic [2:0]  mem_memop,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  input  logic        mem_ready
);

  localparam int unsigned STREAK_W =
    (CPU_BURST_MAX < 1) ? 1 : $clog2(CPU_BURST_MAX + 1);
  localparam logic [STREAK_W-1:0] BURST_MAX = STREAK_W'(CPU_BURST_MAX);

  arb_state_e state_q, state_d;

  logic [STREAK_W-1:0] streak_q, streak_d;

  logic        mem_req_q,   mem_req_d;
  logic        mem_we_q,    mem_we_d;
  logic [2:0]  mem_memop_q, mem_memop_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wd_q,    mem_wd_d;
  logic [31:0] cpu_rd_q,    cpu_rd_d;
  logic [31:0] dma_rd_q,    dma_rd_d;
  logic        cpu_err_q,   cpu_err_d;
  logic        dma_done_q,  dma_done_d;
  logic        dma_err_q,   dma_err_d;

  logic in_acc;
  logic wait_expired;
  logic grant_cpu;

  assign in_acc = (state_q == CPU_ACC) || (state_q == DMA_ACC);

  // CPU wins unless DMA is waiting and the CPU has used up its burst.
  assign grant_cpu = cpu_req && (!dma_req || (streak_q != BURST_MAX));

  mem_arb_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (!in_acc),
    .en     (in_acc && !mem_ready),
    .expired(wait_expired)
  );

  // Next-state, grant, completion and timeout handling.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_memop_d = mem_memop_q;
    mem_addr_d  = mem_addr_q;
    mem_wd_d    = mem_wd_q;
    cpu_rd_d    = cpu_rd_q;
    dma_rd_d    = dma_rd_q;
    cpu_err_d   = 1'b0;
    dma_done_d  = 1'b0;
    dma_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!dma_req) begin
          streak_d = '0;
        end
        if (grant_cpu) begin
          state_d     = CPU_ACC;
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_we;
          mem_memop_d = cpu_memop;
          mem_addr_d  = cpu_addr;
          mem_wd_d    = cpu_wd;
          // grant_cpu implies streak_q < BURST_MAX here, so this saturates.
          if (dma_req) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (dma_req) begin
          state_d     = DMA_ACC;
          mem_req_d   = 1'b1;
          mem_we_d    = dma_we;
          mem_memop_d = MEMOP_WORD;
          mem_addr_d  = dma_addr;
          mem_wd_d    = dma_wd;
          streak_d    = '0;
        end
      end

      CPU_ACC: begin
        if (mem_ready) begin
          state_d   = CPU_DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            cpu_rd_d = mem_rd;
          end
        end else if (wait_expired) begin
          state_d   = CPU_DONE;
          mem_req_d = 1'b0;
          cpu_rd_d  = '0;
          cpu_err_d = 1'b1;
        end
      end

      DMA_ACC: begin
        if (mem_ready) begin
          state_d    = DMA_DONE;
          mem_req_d  = 1'b0;
          dma_done_d = 1'b1;
          if (!mem_we_q) begin
            dma_rd_d = mem_rd;
          end
        end else if (wait_expired) begin
          state_d    = DMA_DONE;
          mem_req_d  = 1'b0;
          dma_rd_d   = '0;
          dma_done_d = 1'b1;
          dma_err_d  = 1'b1;
        end
      end

      CPU_DONE, DMA_DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, streak counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_memop_q <= 3'b000;
      mem_addr_q  <= '0;
      mem_wd_q    <= '0;
      cpu_rd_q    <= '0;
      dma_rd_q    <= '0;
      cpu_err_q   <= 1'b0;
      dma_done_q  <= 1'b0;
      dma_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_memop_q <= mem_memop_d;
      mem_addr_q  <= mem_addr_d;
      mem_wd_q    <= mem_wd_d;
      cpu_rd_q    <= cpu_rd_d;
      dma_rd_q    <= dma_rd_d;
      cpu_err_q   <= cpu_err_d;
      dma_done_q  <= dma_done_d;
      dma_err_q   <= dma_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_memop = mem_memop_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wd    = mem_wd_q;
  assign cpu_rd    = cpu_rd_q;
  assign dma_rd    = dma_rd_q;
  assign cpu_err   = cpu_err_q;
  assign dma_done  = dma_done_q;
  assign dma_err   = dma_err_q;

  // The pipeline is released only in the CPU's own DONE cycle.
  assign cpu_stall = cpu_req && (state_q != CPU_DONE);

endmodule
